// File: rtl/bus_pkg.sv
// Shared types and constants for the single-master bus fabric.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  localparam logic [1:0] HB_BYTE = 2'd0;
  localparam logic [1:0] HB_HALF = 2'd1;
  localparam logic [1:0] HB_WORD = 2'd2;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/bus_addr_decode.sv
// Region index to one-hot chip-enable; o_valid low when the index names no slave.
module bus_addr_decode #(
  parameter int N_SLAVES = 8,
  parameter int IDX_W    = 4
) (
  input  logic [IDX_W-1:0]    i_idx,
  output logic [N_SLAVES-1:0] o_ce,
  output logic                o_valid
);

  always_comb begin
    o_ce    = '0;
    o_valid = 1'b0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (i_idx == IDX_W'(k)) begin
        o_ce[k] = 1'b1;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_interconnect.sv
// Single-master, N-slave bus fabric: region decode, req/gnt FSM, grant timeout,
// decode-error response, error address capture and saturating error counter with IRQ.
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int N_SLAVES = 8,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SEL_MSB  = 31,
  parameter int SEL_LSB  = 28,
  parameter int TIMEOUT  = 16
) (
  input  logic                       i_CLK,
  input  logic                       i_RST,
  input  logic [ADDR_W-1:0]          i_M_ADDR,
  input  logic [DATA_W-1:0]          i_M_WDATA,
  input  logic                       i_M_WE,
  input  logic [1:0]                 i_M_HB,
  input  logic                       i_M_REQ,
  output logic [DATA_W-1:0]          o_M_RDATA,
  output logic                       o_M_GNT,
  output logic                       o_M_ERR,
  output logic [N_SLAVES-1:0]        o_S_CE,
  output logic                       o_S_REQ,
  output logic [ADDR_W-1:0]          o_S_ADDR,
  output logic [DATA_W-1:0]          o_S_WDATA,
  output logic                       o_S_WE,
  output logic [1:0]                 o_S_HB,
  input  logic [N_SLAVES*DATA_W-1:0] i_S_RDATA,
  input  logic [N_SLAVES-1:0]        i_S_GNT,
  output logic [ADDR_W-1:0]          o_ERR_ADDR,
  output logic [ERR_CNT_W-1:0]       o_ERR_CNT,
  output logic                       o_ERR_IRQ
);

  localparam int         IDX_W    = SEL_MSB - SEL_LSB + 1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t                r_state, w_next;
  logic [IDX_W-1:0]      w_idx, r_idx;
  logic [N_SLAVES-1:0]   w_dec_ce, w_ce, r_s_ce;
  logic                  w_dec_vld, r_dec_err;
  logic [7:0]            r_tmo;
  logic                  w_sel_gnt;
  logic [DATA_W-1:0]     w_sel_rdata, w_rdata, r_m_rdata;
  logic                  w_sreq, w_gnt, w_merr, r_s_req, r_m_gnt, r_m_err, r_err_irq;
  logic [ADDR_W-1:0]     r_s_addr, r_err_addr;
  logic [DATA_W-1:0]     r_s_wdata;
  logic                  r_s_we;
  logic [1:0]            r_s_hb;
  logic [ERR_CNT_W-1:0]  r_err_cnt;

  assign w_idx = i_M_ADDR[SEL_MSB:SEL_LSB];

  bus_addr_decode #(.N_SLAVES(N_SLAVES), .IDX_W(IDX_W)) u_decode (
    .i_idx   (w_idx),
    .o_ce    (w_dec_ce),
    .o_valid (w_dec_vld)
  );

  always_comb begin
    w_sel_gnt   = 1'b0;
    w_sel_rdata = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_sel_gnt   = i_S_GNT[k];
        w_sel_rdata = i_S_RDATA[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Decode errors spend one ACCESS cycle with no CE so error and grant latencies match.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_M_REQ) w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (r_dec_err)              w_next = ST_ERR;
        else if (w_sel_gnt)         w_next = ST_RESP;
        else if (r_tmo == TMO_LAST) w_next = ST_ERR;
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ce    = '0;
    w_sreq  = 1'b0;
    if (r_state == ST_IDLE && w_next == ST_ACCESS) begin
      w_ce   = w_dec_ce;
      w_sreq = w_dec_vld;
    end else if (r_state == ST_ACCESS && w_next == ST_ACCESS) begin
      w_ce   = r_s_ce;
      w_sreq = r_s_req;
    end
    w_gnt   = (w_next == ST_RESP) || (w_next == ST_ERR);
    w_merr  = (w_next == ST_ERR);
    w_rdata = (w_next == ST_RESP && !r_s_we) ? w_sel_rdata : '0;
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_s_ce    <= '0;
      r_s_req   <= 1'b0;
      r_m_gnt   <= 1'b0;
      r_m_err   <= 1'b0;
      r_err_irq <= 1'b0;
      r_m_rdata <= '0;
    end else begin
      r_s_ce    <= w_ce;
      r_s_req   <= w_sreq;
      r_m_gnt   <= w_gnt;
      r_m_err   <= w_merr;
      r_err_irq <= w_merr;
      r_m_rdata <= w_rdata;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
      r_s_we     <= 1'b0;
      r_s_hb     <= '0;
      r_idx      <= '0;
      r_dec_err  <= 1'b0;
      r_tmo      <= '0;
      r_err_addr <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (r_state == ST_IDLE && i_M_REQ) begin
        r_s_addr  <= i_M_ADDR;
        r_s_wdata <= i_M_WDATA;
        r_s_we    <= i_M_WE;
        r_s_hb    <= i_M_HB;
        r_idx     <= w_idx;
        r_dec_err <= !w_dec_vld;
        r_tmo     <= '0;
      end else if (r_state == ST_ACCESS) begin
        r_tmo <= r_tmo + 8'd1;
      end
      if (w_next == ST_ERR) begin
        r_err_addr <= r_s_addr;
        if (r_err_cnt != ERR_CNT_MAX) r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign o_S_CE     = r_s_ce;
  assign o_S_REQ    = r_s_req;
  assign o_S_ADDR   = r_s_addr;
  assign o_S_WDATA  = r_s_wdata;
  assign o_S_WE     = r_s_we;
  assign o_S_HB     = r_s_hb;
  assign o_M_GNT    = r_m_gnt;
  assign o_M_ERR    = r_m_err;
  assign o_M_RDATA  = r_m_rdata;
  assign o_ERR_IRQ  = r_err_irq;
  assign o_ERR_ADDR = r_err_addr;
  assign o_ERR_CNT  = r_err_cnt;

endmodule

// File: tb/tb_bus_interconnect.sv
// Table-driven bench for bus_interconnect with a response scoreboard.
module tb_bus_interconnect;
  import bus_pkg::*;

  localparam int NS = 8;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     m_addr, m_wdata;
  logic            m_we;
  logic [1:0]      m_hb;
  logic            m_req;
  logic [31:0]     o_M_RDATA;
  logic            o_M_GNT, o_M_ERR;
  logic [NS-1:0]   o_S_CE;
  logic            o_S_REQ;
  logic [31:0]     o_S_ADDR, o_S_WDATA;
  logic            o_S_WE;
  logic [1:0]      o_S_HB;
  logic [NS*DW-1:0] s_rdata;
  logic [NS-1:0]   s_gnt;
  logic [31:0]     o_ERR_ADDR;
  logic [7:0]      o_ERR_CNT;
  logic            o_ERR_IRQ;

  logic [NS-1:0]   gnt_en, force_gnt;
  logic [31:0]     sd [NS];

  always #5 clk = ~clk;

  // Combinational slaves: a slave grants while selected, requested and enabled.
  assign s_gnt = (gnt_en & o_S_CE & {NS{o_S_REQ}}) | force_gnt;
  always_comb begin
    s_rdata = '0;
    for (int k = 0; k < NS; k++) s_rdata[k*DW +: DW] = sd[k];
  end

  bus_interconnect #(
    .N_SLAVES(NS), .ADDR_W(32), .DATA_W(DW), .SEL_MSB(31), .SEL_LSB(28), .TIMEOUT(16)
  ) dut (
    .i_CLK(clk), .i_RST(rst),
    .i_M_ADDR(m_addr), .i_M_WDATA(m_wdata), .i_M_WE(m_we), .i_M_HB(m_hb), .i_M_REQ(m_req),
    .o_M_RDATA(o_M_RDATA), .o_M_GNT(o_M_GNT), .o_M_ERR(o_M_ERR),
    .o_S_CE(o_S_CE), .o_S_REQ(o_S_REQ), .o_S_ADDR(o_S_ADDR), .o_S_WDATA(o_S_WDATA),
    .o_S_WE(o_S_WE), .o_S_HB(o_S_HB), .i_S_RDATA(s_rdata), .i_S_GNT(s_gnt),
    .o_ERR_ADDR(o_ERR_ADDR), .o_ERR_CNT(o_ERR_CNT), .o_ERR_IRQ(o_ERR_IRQ)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  hb;
    logic [7:0]  en;
    logic [7:0]  frc;
    logic [7:0]  ce;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t tbl [8];
  vec_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd, input logic we,
                              input logic [1:0] hb, input logic [7:0] en, input logic [7:0] frc,
                              input logic [7:0] ce, input logic err, input logic [31:0] rd,
                              input int lat);
    vec_t v;
    v.addr = a; v.wdata = wd; v.we = we; v.hb = hb; v.en = en; v.frc = frc;
    v.ce = ce; v.err = err; v.rdata = rd; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one transaction, then watch cycle by cycle until the grant pulse.
  task automatic run(input vec_t v, input bit tail);
    vec_t e;
    int   lat;
    bit   seen;
    @(negedge clk);
    gnt_en = v.en; force_gnt = v.frc;
    m_addr = v.addr; m_wdata = v.wdata; m_we = v.we; m_hb = v.hb; m_req = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("s_addr", o_S_ADDR, v.addr);
        chk("s_wdata", o_S_WDATA, v.wdata);
        chk("s_we", o_S_WE, v.we);
        chk("s_hb", o_S_HB, v.hb);
        chk("s_req", o_S_REQ, v.ce != 8'h00);
      end
      if (lat == v.lat - 1) chk("s_ce_wait", o_S_CE, v.ce);
      if (o_M_GNT) begin
        seen = 1'b1;
        e = sb.pop_front();
        chk("gnt_latency", lat, e.lat);
        chk("m_err", o_M_ERR, e.err);
        chk("m_rdata", o_M_RDATA, e.rdata);
        chk("err_irq", o_ERR_IRQ, e.err);
        chk("s_ce_at_gnt", o_S_CE, 8'h00);
        if (e.err) begin
          exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
          chk("err_addr", o_ERR_ADDR, e.addr);
          chk("err_cnt", o_ERR_CNT, exp_cnt);
        end
      end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL gnt_wait: no grant within 40 cycles for addr %08h", v.addr);
      void'(sb.pop_front());
    end
    m_req = 1'b0; force_gnt = '0;
    if (tail) begin
      @(negedge clk);
      chk("gnt_pulse_end", o_M_GNT, 1'b0);
      chk("rdata_idle", o_M_RDATA, 32'h0);
      chk("irq_pulse_end", o_ERR_IRQ, 1'b0);
    end
  endtask

  initial begin
    vec_t d;
    rst = 1'b1; m_addr = '0; m_wdata = '0; m_we = 1'b0; m_hb = '0; m_req = 1'b0;
    gnt_en = '1; force_gnt = '0;
    for (int k = 0; k < NS; k++) sd[k] = 32'hC0DE_0000 | 32'(k);
    sd[0] = 32'hDEAD_BEEF;

    repeat (2) @(negedge clk);
    chk("rst_gnt", o_M_GNT, 1'b0);
    chk("rst_ce", o_S_CE, 8'h00);
    chk("rst_req", o_S_REQ, 1'b0);
    chk("rst_cnt", o_ERR_CNT, 8'h00);
    chk("rst_saddr", o_S_ADDR, 32'h0);
    rst = 1'b0;

    tbl[0] = mk(32'h0000_0010, 32'h0,         1'b0, HB_WORD, 8'hFF, 8'h00, 8'h01, 1'b0, 32'hDEAD_BEEF, 2);
    tbl[1] = mk(32'h2000_0000, 32'h55,        1'b1, HB_BYTE, 8'hFF, 8'h00, 8'h04, 1'b0, 32'h0,         2);
    tbl[2] = mk(32'h5000_0004, 32'h0,         1'b0, HB_HALF, 8'hFF, 8'h00, 8'h20, 1'b0, 32'hC0DE_0005, 2);
    tbl[3] = mk(32'h7FFF_FFFC, 32'h0,         1'b0, HB_WORD, 8'hFF, 8'h00, 8'h80, 1'b0, 32'hC0DE_0007, 2);
    tbl[4] = mk(32'h9000_0000, 32'h1234,      1'b0, HB_WORD, 8'hFF, 8'h00, 8'h00, 1'b1, 32'h0,         2);
    tbl[5] = mk(32'h1000_0040, 32'h0,         1'b0, HB_WORD, 8'hFD, 8'h08, 8'h02, 1'b1, 32'h0,         17);
    tbl[6] = mk(32'hF000_0008, 32'h0,         1'b1, HB_WORD, 8'hFF, 8'h00, 8'h00, 1'b1, 32'h0,         2);
    tbl[7] = mk(32'h3000_0100, 32'hA5A5_5A5A, 1'b1, HB_WORD, 8'hFF, 8'h00, 8'h08, 1'b0, 32'h0,         2);

    for (int i = 0; i < 8; i++) run(tbl[i], 1'b0);

    run(tbl[0], 1'b1);

    // Drive the error counter to 256 errors in total.
    d = tbl[4];
    for (int i = 0; i < 253; i++) begin
      d.addr = {4'(8 + (i % 8)), 28'(i * 4)};
      run(d, 1'b0);
    end
    chk("err_cnt_sat", o_ERR_CNT, 8'd255);

    // Reset while a slave is stalling.
    @(negedge clk);
    gnt_en = 8'h00; m_addr = 32'h1000_0040; m_we = 1'b0; m_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_ce", o_S_CE, 8'h02);
    #1 rst = 1'b1;
    #1;
    chk("arst_ce", o_S_CE, 8'h00);
    chk("arst_req", o_S_REQ, 1'b0);
    chk("arst_cnt", o_ERR_CNT, 8'h00);
    chk("arst_saddr", o_S_ADDR, 32'h0);
    chk("arst_erraddr", o_ERR_ADDR, 32'h0);
    m_req = 1'b0; gnt_en = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_gnt", o_M_GNT, 1'b0);
    end
    rst = 1'b0;
    exp_cnt = 0;
    sb.delete();
    run(tbl[0], 1'b1);
    run(tbl[4], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
